bram_add_ctrl: RTL
==================

BRAM_ADD_CTRL -- requirements
Module: bram_add_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the BRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, the BRAM data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle run request, sampled only in IDLE.
REQ-006 SHALL have port len, input, ADDR_W, the last element index; a run covers addresses 0..len (1 to 256 elements).
REQ-007 SHALL have ports ena1, input to BRAM (output of this block), 1, and addra1, output, ADDR_W, forming the operand-A read port; douta1 is an input of DATA_W.
REQ-008 SHALL have ports ena2, output, 1, and addra2, output, ADDR_W, forming the operand-B read port; douta2 is an input of DATA_W.
REQ-009 SHALL have result write port ena3, output, 1; wea3, output, 1; addra3, output, ADDR_W; dina3, output, DATA_W.
REQ-010 SHALL have busy, output, 1; done, output, 1; ovf, output, 1.

Function
REQ-011 SHALL implement FSM states IDLE, RD, CAP, WR, FIN.
REQ-012 In IDLE with start=1, SHALL latch len, clear idx and ovf, and go to RD; start in any other state SHALL be ignored.
REQ-013 In RD, SHALL drive ena1=ena2=1 and addra1=addra2=idx for exactly one cycle, then go to CAP.
REQ-014 BRAM read latency is fixed at 1 cycle; in CAP, douta1/douta2 SHALL be captured and the sum registered, then the FSM goes to WR.
REQ-015 Sum SHALL be unsigned, DATA_W+1 bits wide internally; bit DATA_W is the carry-out.
REQ-016 In WR, SHALL drive ena3=wea3=1, addra3=idx, and dina3=the registered result for exactly one cycle.
REQ-017 In WR, if idx==len, SHALL go to FIN; otherwise SHALL increment idx and go to RD.
REQ-018 In FIN, SHALL pulse done=1 for exactly one cycle, then go to IDLE.
REQ-019 busy SHALL be 1 in RD, CAP, WR, and FIN, and 0 in IDLE.
REQ-020 Each element SHALL take 3 cycles; done SHALL assert 3*(len+1)+1 cycles after the start-sampling edge.
REQ-021 ovf SHALL be sticky and set on any carry-out during the run; it SHALL hold its value after done until the next accepted start.
REQ-022 ena1/ena2/ena3/wea3 SHALL be 0 outside their states; addresses and data SHALL be don't-care while their enables are low.
REQ-023 len=8'hFF SHALL process 256 elements; idx SHALL never wrap during a run.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, idx=0, and all outputs 0, including in mid-run.
REQ-025 A run interrupted by reset SHALL not resume; BRAM contents already written are retained.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first clk edge.

Configuration
REQ-027 With SAT_ADD_EN defined, on carry-out dina3 SHALL be all ones (16'hFFFF) and ovf SHALL still set.
REQ-028 With SAT_ADD_EN undefined, dina3 SHALL be the low DATA_W bits of the sum (wrap-around).

Verification
REQ-029 Reset, then start with len=0, A[0]=16'h0003, B[0]=16'h0004 -> one write of addr 0 with 16'h0007; done 4 cycles after start; ovf=0.
REQ-030 len=3, A={1,2,3,4}, B={10,20,30,40} -> writes 11,22,33,44 at addrs 0..3 in order; done 13 cycles after start; busy high throughout.
REQ-031 len=0, A=16'hFFFF, B=16'h0002 -> ovf=1; dina3=16'h0001 without SAT_ADD_EN, 16'hFFFF with it.
REQ-032 Pulse start during CAP of a len=2 run -> run unaffected; exactly 3 writes; one done pulse.
REQ-033 Assert rst_n=0 during the WR of element 1 (len=5) -> outputs 0 in the same cycle; no further writes; the next start with len=0 completes normally.
REQ-034 len=8'hFF -> 256 writes, last at addr 8'hFF; done 769 cycles after start.

Source files
------------

// File: rtl/bram_add_ctrl.sv
// Element-wise adder: C[i] = A[i] + B[i] for i = 0..len over two 1-cycle-latency BRAM read ports.
// Three cycles per element (RD, CAP, WR). done follows 3*(len+1)+1 edges after start. Define SAT_ADD_EN to clamp on carry.
module bram_add_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              ena1,
  output logic [ADDR_W-1:0] addra1,
  input  logic [DATA_W-1:0] douta1,
  output logic              ena2,
  output logic [ADDR_W-1:0] addra2,
  input  logic [DATA_W-1:0] douta2,
  output logic              ena3,
  output logic              wea3,
  output logic [ADDR_W-1:0] addra3,
  output logic [DATA_W-1:0] dina3,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, douta1} + {1'b0, douta2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      idx   <= '0;
      res   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      // done is registered off FIN so it lands one edge after the last write
      done  <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          idx   <= '0;
          ovf   <= 1'b0;
        end
        CAP: begin
          ovf <= ovf | sum[DATA_W];
`ifdef SAT_ADD_EN
          res <= sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
          res <= sum[DATA_W-1:0];
`endif
        end
        WR: if (idx != len_q) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt    = state;
    ena1   = 1'b0;
    ena2   = 1'b0;
    ena3   = 1'b0;
    wea3   = 1'b0;
    addra1 = '0;
    addra2 = '0;
    addra3 = '0;
    dina3  = '0;
    busy   = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = RD;
      end
      RD: begin
        ena1   = 1'b1;
        ena2   = 1'b1;
        addra1 = idx;
        addra2 = idx;
        nxt    = CAP;
      end
      CAP: nxt = WR;
      WR: begin
        ena3   = 1'b1;
        wea3   = 1'b1;
        addra3 = idx;
        dina3  = res;
        nxt    = (idx == len_q) ? FIN : RD;
      end
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

endmodule
